// File: rtl/fio_mem_dump_ctrl_pkg.sv
// Shared widths and FSM state type for the FileIO MEM dump reader.
package fio_pkg;

  localparam int FIO_ADDR_WIDTH     = 9;
  localparam int FIO_LINE_WIDTH     = 256;
  localparam int FIO_WORD_WIDTH     = 32;
  localparam int FIO_RD_LAT         = 1;
  localparam int FIO_WORDS_PER_LINE = FIO_LINE_WIDTH / FIO_WORD_WIDTH;
  localparam int FIO_WCNT_W         = $clog2(FIO_WORDS_PER_LINE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    FIN   = 3'd4
  } dump_state_t;

endpackage

// File: rtl/fio_mem_dump_ctrl_if.sv
// Command, MEM read port and output word stream of the dump reader.
interface fio_mem_dump_ctrl_if;
  import fio_pkg::*;

  logic                      start;
  logic [FIO_ADDR_WIDTH-1:0] first_addr;
  logic [FIO_ADDR_WIDTH-1:0] last_addr;
  logic [FIO_ADDR_WIDTH-1:0] fio_addr;
  logic [FIO_LINE_WIDTH-1:0] fio_read_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [FIO_WORD_WIDTH-1:0] m_data;
  logic                      m_last;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, first_addr, last_addr, fio_read_data, m_ready,
    output fio_addr, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output start, first_addr, last_addr, fio_read_data, m_ready,
    input  fio_addr, m_valid, m_data, m_last, busy, done
  );

endinterface

// File: rtl/fio_mem_dump_ctrl_serializer.sv
// Holds one MEM line and emits it MSB word first under valid/ready.
module fio_line_serializer
  import fio_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic [FIO_LINE_WIDTH-1:0] line_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [FIO_WORD_WIDTH-1:0] data_o,
  output logic [FIO_WCNT_W-1:0]     word_cnt_o,
  output logic                      last_word_o
);

  localparam logic [FIO_WCNT_W-1:0] LAST_IDX = FIO_WCNT_W'(FIO_WORDS_PER_LINE - 1);

  logic [FIO_LINE_WIDTH-1:0] line_q, line_d;
  logic [FIO_WCNT_W-1:0]     cnt_q, cnt_d;
  logic                      valid_q, valid_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    line_d  = line_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      line_d  = line_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      line_d = line_q << FIO_WORD_WIDTH;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) valid_d = 1'b0;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = line_q[FIO_LINE_WIDTH-1 -: FIO_WORD_WIDTH];
  assign word_cnt_o  = cnt_q;
  assign last_word_o = valid_q && (cnt_q == LAST_IDX);

endmodule

// File: rtl/fio_mem_dump_ctrl.sv
// Walks a MEM line range through the FileIO read port and streams each line as 32-bit words.
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | fio_addr presented for cur_addr
//   WAIT  | counting down read latency, capture line at lat_cnt==1
//   SEND  | serializer streaming the captured line
//   FIN   | drop busy, pulse done
module fio_mem_dump_ctrl
  import fio_pkg::*;
#(
  parameter int RD_LAT = FIO_RD_LAT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fio_mem_dump_ctrl_if.master  dump_io
);

  localparam logic [2:0]            LAT_INIT = 3'(RD_LAT);
  localparam logic [FIO_WCNT_W-1:0] LAST_IDX = FIO_WCNT_W'(FIO_WORDS_PER_LINE - 1);

  dump_state_t               state_q, state_d;
  logic [FIO_ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [FIO_ADDR_WIDTH-1:0] last_q, last_d;
  logic [FIO_ADDR_WIDTH-1:0] fio_addr_q, fio_addr_d;
  logic [2:0]                lat_q, lat_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      load;
  logic                      ser_valid;
  logic                      ser_last_word;
  logic [FIO_WCNT_W-1:0]     ser_word_cnt;
  logic [FIO_WORD_WIDTH-1:0] ser_data;

  fio_line_serializer u_ser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load),
    .line_i      (dump_io.fio_read_data),
    .ready_i     (dump_io.m_ready),
    .valid_o     (ser_valid),
    .data_o      (ser_data),
    .word_cnt_o  (ser_word_cnt),
    .last_word_o (ser_last_word)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      last_q     <= '0;
      fio_addr_q <= '0;
      lat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      fio_addr_q <= fio_addr_d;
      lat_q      <= lat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    fio_addr_d = fio_addr_q;
    lat_d      = lat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_io.start) begin
          cur_d  = dump_io.first_addr;
          last_d = dump_io.last_addr;
          busy_d = 1'b1;
          // An inverted range skips the read entirely but still reports done.
          if (dump_io.first_addr > dump_io.last_addr) begin
            state_d = FIN;
          end else begin
            fio_addr_d = dump_io.first_addr;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == 3'd1) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ser_last_word && dump_io.m_ready) begin
          // Compare before increment so the top line never wraps to 0.
          if (cur_q == last_q) begin
            state_d = FIN;
          end else begin
            cur_d      = cur_q + 1'b1;
            fio_addr_d = cur_q + 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dump_io.fio_addr = fio_addr_q;
  assign dump_io.m_valid  = ser_valid;
  assign dump_io.m_data   = ser_data;
  assign dump_io.m_last   = ser_valid && (cur_q == last_q) && (ser_word_cnt == LAST_IDX);
  assign dump_io.busy     = busy_q;
  assign dump_io.done     = done_q;

endmodule

// File: tb/tb_fio_mem_dump_ctrl.sv
// Scoreboard bench for fio_mem_dump_ctrl with a 1-cycle sync ROM model of MEM.
module tb_fio_mem_dump_ctrl;
  import fio_pkg::*;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        nl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fio_mem_dump_ctrl_if bus ();

  fio_mem_dump_ctrl #(.RD_LAT(1)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .dump_io (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   xfer_cnt = 0;
  int   valid_cycles = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   last_xfer_cyc = 0;
  int   wrap_reads = 0;
  bit   gap_mode = 1'b0;
  bit   rand_rdy = 1'b0;
  bit   prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  function automatic logic [31:0] word_of(int a, int s);
    return {4'hA, 3'(s), 9'(a), 16'hBEEF ^ 16'(a * 8 + s)};
  endfunction

  function automatic logic [255:0] line_of(int a);
    logic [255:0] v;
    for (int s = 0; s < 8; s++) v[s*32 +: 32] = word_of(a, s);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // MEM model: synchronous ROM, data one cycle after the address
  always @(posedge clk) bus.fio_read_data <= line_of(int'(bus.fio_addr));

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.m_valid), 64'd1);
        chk("stall_data", 64'(bus.m_data), 64'(prev_data));
        chk("stall_last", 64'(bus.m_last), 64'(prev_last));
      end
      if (bus.m_valid) valid_cycles++;
      if (bus.busy && bus.fio_addr == '0) wrap_reads++;
      if (bus.m_valid && bus.m_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(bus.m_data), 64'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_data", 64'(bus.m_data), 64'(e.d));
          chk("word_last", 64'(bus.m_last), 64'(e.l));
          if (gap_mode && e.nl) chk("line_gap", 64'(cyc - last_xfer_cyc), 64'd3);
        end
        last_xfer_cyc = cyc;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  int start_cyc;

  task automatic start_dump(input int f, input int l);
    if (f <= l)
      for (int a = f; a <= l; a++)
        for (int s = 7; s >= 0; s--)
          exp_q.push_back('{word_of(a, s), (a == l) && (s == 0), (s == 7) && (a != f)});
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.first_addr = 9'(f);
    bus.last_addr  = 9'(l);
    start_cyc      = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget, output int dcyc);
    int n0 = done_cnt;
    int k = 0;
    dcyc = -1;
    while (done_cnt == n0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({nm, "_done_seen"}, 64'(done_cnt != n0), 64'd1);
    if (done_cnt != n0) begin
      dcyc = done_cyc;
      chk({nm, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      #1;
      chk({nm, "_done_width"}, 64'(bus.done), 64'd0);
    end
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int k = 0;
    while (xfer_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("xfer_wait", 64'(xfer_cnt >= target), 64'd1);
  endtask

  initial begin
    int dc, x0, v0, d0, f, l;
    bus.start      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    #2;
    chk("rst_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_data", 64'(bus.m_data), 64'd0);
    chk("rst_last", 64'(bus.m_last), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_addr", 64'(bus.fio_addr), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // T1 single line
    gap_mode = 1'b1;
    x0 = xfer_cnt;
    start_dump(5, 5);
    wait_done("t1", 100, dc);
    chk("t1_words", 64'(xfer_cnt - x0), 64'd8);
    chk("t1_done_lat", 64'(dc - last_xfer_cyc), 64'd2);

    // T2 range with line gaps
    x0 = xfer_cnt;
    start_dump(1, 16);
    wait_done("t2", 1000, dc);
    chk("t2_words", 64'(xfer_cnt - x0), 64'd128);
    gap_mode = 1'b0;

    // T3 random backpressure
    rand_rdy = 1'b1;
    x0 = xfer_cnt;
    start_dump(0, 3);
    wait_done("t3", 2000, dc);
    chk("t3_words", 64'(xfer_cnt - x0), 64'd32);
    rand_rdy = 1'b0;

    // T4 empty range and top-of-memory line
    v0 = valid_cycles;
    start_dump(4, 3);
    wait_done("t4e", 20, dc);
    chk("t4e_done_lat", 64'(dc - start_cyc), 64'd2);
    chk("t4e_no_valid", 64'(valid_cycles - v0), 64'd0);
    x0 = xfer_cnt;
    wrap_reads = 0;
    start_dump(511, 511);
    wait_done("t4t", 100, dc);
    chk("t4t_words", 64'(xfer_cnt - x0), 64'd8);
    chk("t4t_no_wrap", 64'(wrap_reads), 64'd0);

    // T5 start while busy
    x0 = xfer_cnt;
    d0 = done_cnt;
    start_dump(0, 1);
    wait_xfers(x0 + 3, 100);
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.first_addr = 9'd40;
    bus.last_addr  = 9'd45;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("t5", 200, dc);
    repeat (10) @(negedge clk);
    chk("t5_words", 64'(xfer_cnt - x0), 64'd16);
    chk("t5_one_done", 64'(done_cnt - d0), 64'd1);

    // T6 reset mid-dump
    x0 = xfer_cnt;
    start_dump(0, 7);
    wait_xfers(x0 + 11, 200);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(bus.m_valid), 64'd0);
    chk("t6_data", 64'(bus.m_data), 64'd0);
    chk("t6_last", 64'(bus.m_last), 64'd0);
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_addr", 64'(bus.fio_addr), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    x0 = xfer_cnt;
    start_dump(0, 0);
    wait_done("t6r", 100, dc);
    chk("t6r_words", 64'(xfer_cnt - x0), 64'd8);

    // T7 random short ranges under random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      f = int'($urandom_range(0, 508));
      l = (i == 2) ? f - 1 : f + int'($urandom_range(0, 3));
      x0 = xfer_cnt;
      start_dump(f, l);
      wait_done("t7", 2000, dc);
      chk("t7_words", 64'(xfer_cnt - x0), 64'((l >= f) ? (l - f + 1) * 8 : 0));
    end
    rand_rdy = 1'b0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
